// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86 icode, condition and ALU control constants
package y86_pkg;
  localparam logic [3:0] I_RRMOVQ = 4'd2;
  localparam logic [3:0] I_OPQ    = 4'd6;
  localparam logic [3:0] I_JXX    = 4'd7;
  localparam logic [3:0] C_YES = 4'd0;
  localparam logic [3:0] C_LE  = 4'd1;
  localparam logic [3:0] C_L   = 4'd2;
  localparam logic [3:0] C_E   = 4'd3;
  localparam logic [3:0] C_NE  = 4'd4;
  localparam logic [3:0] C_GE  = 4'd5;
  localparam logic [3:0] C_G   = 4'd6;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;
endpackage

// File: rtl/cc_cond_unit_cond_eval.sv
// cond_eval: combinational Y86 condition evaluation against ZF/SF/OF
// ports: ifun (condition selector), zf/sf/of (current CC) -> cnd_raw, ifun_bad (ifun > 6)
module cond_eval
  import y86_pkg::*;
(
  input  logic [3:0] ifun,
  input  logic       zf,
  input  logic       sf,
  input  logic       of,
  output logic       cnd_raw,
  output logic       ifun_bad
);
  logic lt;
  always_comb begin
    lt = sf ^ of;
    cnd_raw = (ifun == C_YES) ? 1'b1 :
              (ifun == C_LE)  ? (lt | zf) :
              (ifun == C_L)   ? lt :
              (ifun == C_E)   ? zf :
              (ifun == C_NE)  ? ~zf :
              (ifun == C_GE)  ? ~lt :
              (ifun == C_G)   ? (~lt & ~zf) : 1'b0;
    ifun_bad = ifun > C_G;
  end
endmodule

// File: rtl/cc_cond_unit.sv
// cc_cond_unit: Y86 condition-code register and jXX/cmovXX condition evaluation
// ports: clk, reset (sync, active-high), valid_in, icode, ifun, alu_out, alu_ovf, cc_inhibit
//        -> zf/sf/of (registered CC), cnd (combinational from registered CC), bad_cond (sticky)
// optional: define CC_PERF_EN to add saturating cc_upd_cnt / cnd_taken_cnt counters
module cc_cond_unit
  import y86_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [3:0]       icode,
  input  logic [3:0]       ifun,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_ovf,
  input  logic             cc_inhibit,
  output logic             zf,
  output logic             sf,
  output logic             of,
  output logic             cnd,
  output logic             bad_cond
`ifdef CC_PERF_EN
  ,
  output logic [CNT_W-1:0] cc_upd_cnt,
  output logic [CNT_W-1:0] cnd_taken_cnt
`endif
);
  logic set_cc, is_cond, cnd_raw, ifun_bad;
  cond_eval u_eval (
    .ifun     (ifun),
    .zf       (zf),
    .sf       (sf),
    .of       (of),
    .cnd_raw  (cnd_raw),
    .ifun_bad (ifun_bad)
  );
  always_comb begin
    set_cc  = valid_in & (icode == I_OPQ) & ~cc_inhibit & ~reset;
    is_cond = valid_in & ((icode == I_RRMOVQ) | (icode == I_JXX));
    cnd     = is_cond & cnd_raw;
  end
  // alu_out is only sampled under set_cc, so X on an idle bus cannot reach the CC
  always_ff @(posedge clk) begin
    if (reset) begin
      zf <= 1'b1;
      sf <= 1'b0;
      of <= 1'b0;
      bad_cond <= 1'b0;
    end else begin
      if (set_cc) begin
        zf <= alu_out == '0;
        sf <= alu_out[WIDTH-1];
        of <= alu_ovf;
      end
      if (is_cond & ifun_bad) bad_cond <= 1'b1;
    end
  end
`ifdef CC_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cc_upd_cnt <= '0;
      cnd_taken_cnt <= '0;
    end else begin
      if (set_cc && !(&cc_upd_cnt)) cc_upd_cnt <= cc_upd_cnt + 1'b1;
      if (cnd && !(&cnd_taken_cnt)) cnd_taken_cnt <= cnd_taken_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_cc_cond_unit.sv
// tb_cc_cond_unit: directed self-checking bench for cc_cond_unit
module tb_cc_cond_unit;
  logic clk = 0, reset = 1, valid_in = 0, alu_ovf = 0, cc_inhibit = 0;
  logic [3:0] icode = 0, ifun = 0;
  logic [63:0] alu_out = 0;
  logic zf, sf, of, cnd, bad_cond;
  int n_cmp = 0, n_bad = 0;
`ifdef CC_PERF_EN
  logic [3:0] cc_upd_cnt, cnd_taken_cnt;
`endif
  cc_cond_unit #(.WIDTH(64), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .icode(icode), .ifun(ifun),
    .alu_out(alu_out), .alu_ovf(alu_ovf), .cc_inhibit(cc_inhibit),
    .zf(zf), .sf(sf), .of(of), .cnd(cnd), .bad_cond(bad_cond)
`ifdef CC_PERF_EN
    , .cc_upd_cnt(cc_upd_cnt), .cnd_taken_cnt(cnd_taken_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic drv(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                     input logic [63:0] a, input logic ov, input logic inh);
    valid_in = v; icode = ic; ifun = fn; alu_out = a; alu_ovf = ov; cc_inhibit = inh;
    #1;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_cc(input string tag, input logic z, input logic s, input logic o);
    chk({tag, "_zf"}, {63'd0, zf}, {63'd0, z});
    chk({tag, "_sf"}, {63'd0, sf}, {63'd0, s});
    chk({tag, "_of"}, {63'd0, of}, {63'd0, o});
  endtask
  initial begin
    drv(0, 0, 0, 0, 0, 0);
    step(); step();
    chk_cc("rst", 1, 0, 0);
    chk("rst_bad", {63'd0, bad_cond}, 0);
    reset = 0;
    drv(1, 7, 3, 0, 0, 0); chk("rst_je", {63'd0, cnd}, 1);
    drv(1, 7, 4, 0, 0, 0); chk("rst_jne", {63'd0, cnd}, 0);
    drv(0, 7, 0, 0, 0, 0); chk("inval_cnd", {63'd0, cnd}, 0);
    drv(1, 6, 0, 0, 0, 0); chk("opq_cnd", {63'd0, cnd}, 0);
    drv(1, 6, 0, 64'hFFFF_FFFF_FFFF_FFFB, 0, 0);
    chk("nobypass", {63'd0, zf}, 1);
    step();
    drv(1, 7, 2, 0, 0, 0);
    chk_cc("neg", 0, 1, 0);
    chk("neg_jl", {63'd0, cnd}, 1);
    drv(1, 7, 6, 0, 0, 0); chk("neg_jg", {63'd0, cnd}, 0);
    drv(1, 6, 0, 64'h8000_0000_0000_0000, 1, 0);
    step();
    drv(1, 2, 5, 0, 0, 0);
    chk_cc("ovf", 0, 1, 1);
    chk("ovf_cmovge", {63'd0, cnd}, 1);
    drv(1, 2, 1, 0, 0, 0); chk("ovf_cmovle", {63'd0, cnd}, 0);
    drv(1, 6, 0, 0, 0, 1); step();
    chk_cc("inhibit", 0, 1, 1);
    drv(0, 6, 0, 0, 0, 0); step();
    chk_cc("novalid", 0, 1, 1);
    drv(1, 6, 0, 0, 0, 0); step();
    chk_cc("upd_zero", 1, 0, 0);
    drv(1, 6, 0, 64'd5, 0, 0); step();
    chk_cc("upd_pos", 0, 0, 0);
    drv(1, 2, 6, 0, 0, 0); chk("pos_cmovg", {63'd0, cnd}, 1);
    reset = 1;
    drv(1, 6, 0, 64'h8000_0000_0000_0000, 1, 0); step();
    chk_cc("rst_wins", 1, 0, 0);
    reset = 0;
    drv(1, 2, 0, 'x, 1'bx, 0); step();
    chk_cc("x_hold", 1, 0, 0);
    chk("x_cmov", {63'd0, cnd}, 1);
    drv(1, 7, 9, 0, 0, 0);
    chk("bad_cnd", {63'd0, cnd}, 0);
    chk("bad_pre", {63'd0, bad_cond}, 0);
    step();
    chk("bad_set", {63'd0, bad_cond}, 1);
    chk_cc("bad_cc", 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drv(1, (i % 2) ? 4'd6 : 4'd7, 4'(i), 64'(i + 1), 0, 0); step();
      chk($sformatf("bad_hold%0d", i), {63'd0, bad_cond}, 1);
    end
    reset = 1; drv(0, 0, 0, 0, 0, 0); step();
    chk("bad_clr", {63'd0, bad_cond}, 0);
    reset = 0;
`ifdef CC_PERF_EN
    chk("cnt_rst_upd", {60'd0, cc_upd_cnt}, 0);
    chk("cnt_rst_tkn", {60'd0, cnd_taken_cnt}, 0);
    for (int i = 0; i < 3; i++) begin drv(1, 6, 0, 0, 0, 0); step(); end
    drv(1, 7, 3, 0, 0, 0); step();
    drv(1, 7, 4, 0, 0, 0); step();
    drv(1, 7, 3, 0, 0, 0); step();
    drv(1, 6, 0, 0, 0, 1); step();
    chk("cnt_upd3", {60'd0, cc_upd_cnt}, 3);
    chk("cnt_tkn2", {60'd0, cnd_taken_cnt}, 2);
    for (int i = 0; i < 20; i++) begin drv(1, 6, 0, 0, 0, 0); step(); end
    chk("cnt_sat", {60'd0, cc_upd_cnt}, 15);
    chk("cnt_tkn_hold", {60'd0, cnd_taken_cnt}, 2);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
